// File: rtl/sm_reg_tracer.sv
// rtl/sm_reg_tracer.sv - per-instruction PC/register snapshot tracer feeding a FWFT trace FIFO
// Define SM_TRACE_TIMESTAMP_EN to prefix every snapshot with a cycle-counter entry (tag 6'h21).
module sm_reg_tracer #(
  parameter logic [31:0] WATCH_MASK = 32'h0000_0004,
  parameter logic [4:0]  PC_ADDR    = 5'd0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_step,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_tag,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic [7:0]  miss_cnt,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] SCAN_MASK = WATCH_MASK & ~32'h1;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t      state, stateNext;
  logic [4:0]  regAddrNext;
  logic [31:0] remain, remainNext;
  logic        first, firstNext;
  logic        pending, pendingNext;
  logic [7:0]  missNext;
  logic        pushEn, done, startNow;
  logic [5:0]  pushTag;
  logic [31:0] pushData;
  logic        tsPhase;
  logic [31:0] tsLatch;

  function automatic logic [4:0] lowestBit(input logic [31:0] m);
    lowestBit = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) lowestBit = 5'(i);
    end
  endfunction

  always_comb begin
    stateNext   = state;
    regAddrNext = regAddr;
    remainNext  = remain;
    firstNext   = first;
    pendingNext = pending;
    missNext    = miss_cnt;
    pushEn      = 1'b0;
    pushTag     = 6'h00;
    pushData    = regData;
    done        = 1'b0;
    startNow    = 1'b0;
    case (state)
      IDLE: ;
      SCAN: begin
        pushEn = 1'b1;
        if (tsPhase) begin
          pushTag  = 6'h21;
          pushData = tsLatch;
        end else begin
          pushTag   = first ? 6'h20 : {1'b0, regAddr};
          firstNext = 1'b0;
          if (remain == 32'd0) begin
            done = 1'b1;
          end else begin
            regAddrNext = lowestBit(remain);
            remainNext  = remain & (remain - 32'd1);
            if ((remain & (remain - 32'd1)) == 32'd0) stateNext = FLUSH;
          end
        end
      end
      FLUSH: begin
        pushEn  = 1'b1;
        pushTag = {1'b0, regAddr};
        done    = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    // The final push cycle can accept a new start, so back-to-back snapshots lose no cycle.
    if (state == IDLE || done) begin
      if (cpu_step || pending) begin
        startNow    = 1'b1;
        stateNext   = SCAN;
        regAddrNext = PC_ADDR;
        remainNext  = SCAN_MASK;
        firstNext   = 1'b1;
        pendingNext = pending & cpu_step;
      end else if (done) begin
        stateNext   = IDLE;
        regAddrNext = PC_ADDR;
      end
    end else if (cpu_step) begin
      if (!pending) pendingNext = 1'b1;
      else if (miss_cnt != 8'hFF) missNext = miss_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      regAddr  <= PC_ADDR;
      remain   <= 32'd0;
      first    <= 1'b0;
      pending  <= 1'b0;
      miss_cnt <= 8'd0;
    end else begin
      state    <= stateNext;
      regAddr  <= regAddrNext;
      remain   <= remainNext;
      first    <= firstNext;
      pending  <= pendingNext;
      miss_cnt <= missNext;
    end
  end

`ifdef SM_TRACE_TIMESTAMP_EN
  logic [31:0] cycleCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt <= 32'd0;
      tsPhase  <= 1'b0;
      tsLatch  <= 32'd0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (startNow) begin
        tsPhase <= 1'b1;
        tsLatch <= cycleCnt;
      end else if (state == SCAN) begin
        tsPhase <= 1'b0;
      end
    end
  end
`else
  assign tsPhase = 1'b0;
  assign tsLatch = 32'd0;
`endif

  assign busy = (state != IDLE);

  logic [5:0]    memTag  [FIFO_DEPTH];
  logic [31:0]   memData [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          full, pop, wrOk;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign wrOk      = pushEn & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrOk) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + {{AW{1'b0}}, wrOk} - {{AW{1'b0}}, pop};
      if (pushEn && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrOk) begin
      memTag[wrPtr]  <= pushTag;
      memData[wrPtr] <= pushData;
    end
  end

  assign out_tag  = out_valid ? memTag[rdPtr]  : 6'h00;
  assign out_data = out_valid ? memData[rdPtr] : 32'd0;

endmodule
